prach_cc_sched: RTL and testbench
=================================

Name: prach_cc_sched

Overview:
- Per-CC occasion scheduler for the long-PRACH front end.
- Consumes the TDM channel index and sync pulse from the 3-CC resync stage. That stream runs at 61.44 Msps with 8 clock ticks per sample and slot k carrying CC k.
- Tracks a sample-time base and runs one occasion FSM per CC (offset, length, enable).
- Emits per-slot qualifiers (valid/first/last) that gate the downstream PRACH datapath, plus done pulses and a sync error flag.

Parameters:
- NUM_CC, 3, number of component carriers; slot k (k < NUM_CC) belongs to CC k.
- SAMP_W, 20, width of the sample counter, offsets and lengths.

Ports:
- clk  in  1  processing clock.
- rst  in  1  synchronous reset, active-high.
- chn  in  8  TDM channel index from the resync stage; only chn[2:0] is used.
- sync_in  in  1  one-cycle pulse; legal only when chn[2:0]==0.
- cfg_wr  in  1  write strobe for the shadow config of CC cfg_cc.
- cfg_cc  in  2  CC index for a write; values >= NUM_CC are ignored.
- cfg_en  in  1  occasion enable.
- cfg_offset  in  SAMP_W  start sample, counted from sync.
- cfg_len  in  SAMP_W  occasion length in samples.
- err_clr  in  1  clears sync_err.
- slot_valid  out  1  the current slot carries an active occasion.
- slot_cc  out  2  CC index for the qualified slot.
- slot_first  out  1  first sample of the occasion.
- slot_last  out  1  last sample of the occasion.
- cc_active  out  NUM_CC  per-CC FSM is in ACTIVE.
- occ_done  out  NUM_CC  one-cycle pulse when an occasion finishes.
- sync_err  out  1  sticky misaligned-sync flag.

Behaviour:
- Reset: all outputs 0; FSMs IDLE; shadow and working config 0; sample_cnt 0.
- Sample boundary: any cycle with chn[2:0]==0.
- sample_cnt:
  - Loads 0 on sync_in.
  - Otherwise increments by 1 on each boundary.
  - Saturates at all-ones.
- Config:
  - cfg_wr writes the shadow config of CC cfg_cc.
  - On sync_in, each non-ACTIVE CC copies shadow to working config.
  - An ACTIVE CC defers the copy to the first sync_in after it returns to IDLE.
  - cfg_wr and sync_in in the same cycle: the written value lands in shadow only and is applied at the following sync.
- Per-CC FSM transitions:
  - IDLE -> ARMED on sync_in, if the newly applied en==1 and len!=0.
  - ARMED -> ACTIVE at the boundary where the updated sample_cnt equals offset. offset==0 goes ACTIVE on the sync cycle itself.
  - ARMED -> IDLE on sync_in if en==0 or len==0. An ARMED CC receiving sync_in with en==1 stays ARMED.
  - ACTIVE: a remaining counter loads len, and decrements at each boundary after the first.
  - ACTIVE -> IDLE at the boundary after the last sample; occ_done[k] pulses for one cycle in that same cycle.
  - sync_in during ACTIVE does not abort the occasion; only sample_cnt restarts.
- Unreachable offsets: an offset beyond saturation never fires, and the CC stays ARMED.
- Slot qualifiers:
  - Registered, 1 cycle after the input cycle with chn[2:0]==k, k < NUM_CC.
  - slot_valid = CC k ACTIVE; slot_cc = k.
  - slot_first asserts on the first sample; slot_last on the last sample. Both assert together when len==1.
  - Slots NUM_CC..7 always produce slot_valid=0.
  - slot_cc, slot_first and slot_last are 0 whenever slot_valid=0.
- sync_err:
  - Set when sync_in arrives with chn[2:0]!=0. That sync is otherwise ignored: no sample_cnt reload, no config apply.
  - err_clr clears it. If err_clr and a new error occur in the same cycle, the flag stays set.
- Reset mid-occasion: all state is abandoned; no occ_done is issued.

Optional Feature:
- Macro: PRACH_CC_SCHED_STATS_EN.
- With the macro defined:
  - Adds output occ_cnt [NUM_CC*16] (CC k at bits 16k+15:16k).
  - Each 16-bit field counts completed occasions, wrapping.
  - Cleared by rst, or by err_clr pulsed while sync_err==0.
- Without the macro: the port and the counters are absent, and behaviour is otherwise identical.

Test Plan:
- CC0 en, offset 4, len 3; sync at chn 0 -> slot_valid for slot_cc 0 on samples 4,5,6 (cycles sync+33, +41, +49). slot_first on the first, slot_last on the third; occ_done[0] pulses at the boundary of sample 7; other CCs silent.
- All three CCs en, offset 0, len 2 -> each sample period gives valid pulses at slots 0,1,2 (cycles +1,+2,+3). slot_first in the first period, slot_last in the second; occ_done = 3'b111 together.
- cfg_wr CC1 (len 5) in the same cycle as sync_in -> CC1 remains IDLE for that frame, then arms on the next sync_in.
- sync_in driven with chn[2:0]==3 -> sync_err=1, sample_cnt continues with no reset, FSMs unchanged; err_clr -> sync_err=0.
- CC2 ACTIVE with len 10; second sync_in after 4 samples -> occasion still emits 10 samples total. A shadow update written meanwhile is applied only at the sync after occ_done[2].
- rst asserted mid-occasion -> next cycle slot_valid=0, cc_active=0, no occ_done. With PRACH_CC_SCHED_STATS_EN, occ_cnt=0.

Source files
------------

// File: rtl/prach_cc_sched.sv
// prach_cc_sched: per-CC long-PRACH occasion scheduler driven by the TDM slot stream of the 3-CC resync stage.
// Optional per-CC completed-occasion counters (occ_cnt) are built when PRACH_CC_SCHED_STATS_EN is defined.
module prach_cc_sched #(
  parameter int NUM_CC = 3,
  parameter int SAMP_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        chn,
  input  logic              sync_in,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_cc,
  input  logic              cfg_en,
  input  logic [SAMP_W-1:0] cfg_offset,
  input  logic [SAMP_W-1:0] cfg_len,
  input  logic              err_clr,
  output logic              slot_valid,
  output logic [1:0]        slot_cc,
  output logic              slot_first,
  output logic              slot_last,
  output logic [NUM_CC-1:0] cc_active,
  output logic [NUM_CC-1:0] occ_done,
  output logic              sync_err
`ifdef PRACH_CC_SCHED_STATS_EN
  ,
  output logic [NUM_CC*16-1:0] occ_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [SAMP_W-1:0] CNT_MAX = {SAMP_W{1'b1}};

  logic [2:0]        slot_idx;
  logic              boundary;
  logic              sync_ok;
  logic              sync_bad;
  logic              unused_chn;
  logic [SAMP_W-1:0] cnt_reg;
  logic [SAMP_W-1:0] cnt_next;
  logic [NUM_CC-1:0] act_next_vec;
  logic [NUM_CC-1:0] first_next_vec;
  logic [NUM_CC-1:0] last_next_vec;
  logic [NUM_CC-1:0] done_next_vec;
  logic              slot_valid_next;
  logic [1:0]        slot_cc_next;
  logic              slot_first_next;
  logic              slot_last_next;
  logic              sync_err_next;
  logic              slot_valid_reg;
  logic [1:0]        slot_cc_reg;
  logic              slot_first_reg;
  logic              slot_last_reg;
  logic [NUM_CC-1:0] occ_done_reg;
  logic              sync_err_reg;

  assign slot_idx   = chn[2:0];
  assign unused_chn = ^chn[7:3];
  assign boundary   = (slot_idx == 3'd0);
  assign sync_ok    = sync_in & boundary;
  // A sync off slot 0 is only flagged; it never touches the time base or config.
  assign sync_bad   = sync_in & ~boundary;

  always_comb begin
    cnt_next = cnt_reg;
    if (sync_ok)
      cnt_next = '0;
    else if (boundary && cnt_reg != CNT_MAX)
      cnt_next = cnt_reg + SAMP_W'(1);
  end

  for (genvar gi = 0; gi < NUM_CC; gi++) begin : g_cc
    state_t            state_reg;
    state_t            state_next;
    logic              sh_en_reg;
    logic [SAMP_W-1:0] sh_off_reg;
    logic [SAMP_W-1:0] sh_len_reg;
    logic              wk_en_reg;
    logic [SAMP_W-1:0] wk_off_reg;
    logic [SAMP_W-1:0] wk_len_reg;
    logic [SAMP_W-1:0] rem_reg;
    logic [SAMP_W-1:0] rem_next;
    logic              apply;
    logic              ap_en;
    logic              ap_go;
    logic [SAMP_W-1:0] ap_off;
    logic [SAMP_W-1:0] ap_len;
    logic              done_next;

    // ap_* is the config in force this cycle, including a copy landing on this sync.
    assign apply  = sync_ok && (state_reg != ST_ACTIVE);
    assign ap_en  = apply ? sh_en_reg  : wk_en_reg;
    assign ap_off = apply ? sh_off_reg : wk_off_reg;
    assign ap_len = apply ? sh_len_reg : wk_len_reg;
    assign ap_go  = ap_en && (ap_len != '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg  <= ST_IDLE;
        sh_en_reg  <= 1'b0;
        sh_off_reg <= '0;
        sh_len_reg <= '0;
        wk_en_reg  <= 1'b0;
        wk_off_reg <= '0;
        wk_len_reg <= '0;
        rem_reg    <= '0;
      end else begin
        if (cfg_wr && cfg_cc == 2'(gi)) begin
          sh_en_reg  <= cfg_en;
          sh_off_reg <= cfg_offset;
          sh_len_reg <= cfg_len;
        end
        if (apply) begin
          wk_en_reg  <= sh_en_reg;
          wk_off_reg <= sh_off_reg;
          wk_len_reg <= sh_len_reg;
        end
        state_reg <= state_next;
        rem_reg   <= rem_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        ST_IDLE, ST_ARMED: begin
          if (sync_ok) begin
            if (!ap_go)
              state_next = ST_IDLE;
            else if (ap_off == '0)
              state_next = ST_ACTIVE;
            else
              state_next = ST_ARMED;
          end else if (state_reg == ST_ARMED && boundary && cnt_next == wk_off_reg) begin
            state_next = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (boundary && rem_reg == SAMP_W'(1))
            state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end

    always_comb begin
      rem_next  = rem_reg;
      done_next = 1'b0;
      if (state_reg != ST_ACTIVE && state_next == ST_ACTIVE)
        rem_next = ap_len;
      else if (state_reg == ST_ACTIVE && boundary)
        rem_next = rem_reg - SAMP_W'(1);
      if (state_reg == ST_ACTIVE && state_next == ST_IDLE)
        done_next = 1'b1;
    end

    assign act_next_vec[gi]   = (state_next == ST_ACTIVE);
    assign first_next_vec[gi] = (rem_next == ap_len);
    assign last_next_vec[gi]  = (rem_next == SAMP_W'(1));
    assign done_next_vec[gi]  = done_next;
    assign cc_active[gi]      = (state_reg == ST_ACTIVE);
  end

  // Qualifiers use post-boundary state so slot 0 of a sample sees that sample's status.
  always_comb begin
    slot_valid_next = 1'b0;
    slot_cc_next    = '0;
    slot_first_next = 1'b0;
    slot_last_next  = 1'b0;
    for (int k = 0; k < NUM_CC; k++) begin
      if (slot_idx == 3'(k) && act_next_vec[k]) begin
        slot_valid_next = 1'b1;
        slot_cc_next    = 2'(k);
        slot_first_next = first_next_vec[k];
        slot_last_next  = last_next_vec[k];
      end
    end
  end

  assign sync_err_next = (sync_err_reg & ~err_clr) | sync_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      slot_valid_reg <= 1'b0;
      slot_cc_reg    <= '0;
      slot_first_reg <= 1'b0;
      slot_last_reg  <= 1'b0;
      occ_done_reg   <= '0;
      sync_err_reg   <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      slot_valid_reg <= slot_valid_next;
      slot_cc_reg    <= slot_cc_next;
      slot_first_reg <= slot_first_next;
      slot_last_reg  <= slot_last_next;
      occ_done_reg   <= done_next_vec;
      sync_err_reg   <= sync_err_next;
    end
  end

  assign slot_valid = slot_valid_reg;
  assign slot_cc    = slot_cc_reg;
  assign slot_first = slot_first_reg;
  assign slot_last  = slot_last_reg;
  assign occ_done   = occ_done_reg;
  assign sync_err   = sync_err_reg;

`ifdef PRACH_CC_SCHED_STATS_EN
  logic [NUM_CC*16-1:0] occ_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || (err_clr && !sync_err_reg)) begin
      occ_cnt_reg <= '0;
    end else begin
      for (int k = 0; k < NUM_CC; k++) begin
        if (done_next_vec[k])
          occ_cnt_reg[16*k +: 16] <= occ_cnt_reg[16*k +: 16] + 16'd1;
      end
    end
  end

  assign occ_cnt = occ_cnt_reg;
`endif

endmodule

// File: tb/tb_prach_cc_sched.sv
// Bench for prach_cc_sched: sample-level reference model checked every cycle, plus hand-derived literal checks.
`timescale 1ns/1ps
module tb_prach_cc_sched;
  localparam int NUM_CC = 3;
  localparam int SAMP_W = 20;
  localparam longint T_SAT = (64'd1 << SAMP_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  chn;
  logic        sync_in;
  logic        cfg_wr;
  logic [1:0]  cfg_cc;
  logic        cfg_en;
  logic [19:0] cfg_offset;
  logic [19:0] cfg_len;
  logic        err_clr;
  logic        slot_valid;
  logic [1:0]  slot_cc;
  logic        slot_first;
  logic        slot_last;
  logic [2:0]  cc_active;
  logic [2:0]  occ_done;
  logic        sync_err;
`ifdef PRACH_CC_SCHED_STATS_EN
  logic [47:0] occ_cnt;
`endif

  always #5 clk = ~clk;

  prach_cc_sched #(.NUM_CC(NUM_CC), .SAMP_W(SAMP_W)) dut (
    .clk(clk), .rst(rst), .chn(chn), .sync_in(sync_in),
    .cfg_wr(cfg_wr), .cfg_cc(cfg_cc), .cfg_en(cfg_en),
    .cfg_offset(cfg_offset), .cfg_len(cfg_len), .err_clr(err_clr),
    .slot_valid(slot_valid), .slot_cc(slot_cc), .slot_first(slot_first),
    .slot_last(slot_last), .cc_active(cc_active), .occ_done(occ_done),
    .sync_err(sync_err)
`ifdef PRACH_CC_SCHED_STATS_EN
    , .occ_cnt(occ_cnt)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  int phase = 0;
  int upper = 0;

  // Reference model: occasion tracked as "samples delivered so far" against a sample clock.
  bit          model_ok = 1'b0;
  longint      m_t;
  bit          m_err;
  bit          m_sh_en [NUM_CC];
  int unsigned m_sh_off[NUM_CC];
  int unsigned m_sh_len[NUM_CC];
  bit          m_en    [NUM_CC];
  int unsigned m_off   [NUM_CC];
  int unsigned m_len   [NUM_CC];
  bit          m_armed [NUM_CC];
  bit          m_act   [NUM_CC];
  int unsigned m_seen  [NUM_CC];
  int unsigned m_cnt   [NUM_CC];
  bit          mb, mvs, mbad, mclr, mwas;
  int          midx;
  logic        e_valid, e_first, e_last, e_err;
  logic [1:0]  e_cc;
  logic [2:0]  e_active, e_done;

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0;
      m_err = 1'b0;
      for (int k = 0; k < NUM_CC; k++) begin
        m_sh_en[k] = 0; m_sh_off[k] = 0; m_sh_len[k] = 0;
        m_en[k] = 0; m_off[k] = 0; m_len[k] = 0;
        m_armed[k] = 0; m_act[k] = 0; m_seen[k] = 0; m_cnt[k] = 0;
      end
      e_valid = 0; e_cc = 0; e_first = 0; e_last = 0;
      e_active = 0; e_done = 0; e_err = 0;
      model_ok = 1'b1;
    end else begin
      mb   = (chn[2:0] == 3'd0);
      mvs  = sync_in && mb;
      mbad = sync_in && !mb;
      mclr = err_clr && !m_err;
      if (mvs) m_t = 0;
      else if (mb && m_t < T_SAT) m_t++;
      e_done = 3'b000;
      for (int k = 0; k < NUM_CC; k++) begin
        mwas = m_act[k];
        if (mb && m_act[k] && m_seen[k] == m_len[k]) begin
          m_act[k] = 0;
          e_done[k] = 1'b1;
        end
        if (mvs && !mwas) begin
          m_en[k] = m_sh_en[k]; m_off[k] = m_sh_off[k]; m_len[k] = m_sh_len[k];
          m_armed[k] = m_en[k] && (m_len[k] != 0);
        end
        if (m_armed[k] && mb && m_t == longint'(m_off[k])) begin
          m_armed[k] = 0;
          m_act[k] = 1;
          m_seen[k] = 0;
        end
        if (m_act[k] && mb) m_seen[k]++;
        if (cfg_wr && cfg_cc == 2'(k)) begin
          m_sh_en[k] = cfg_en; m_sh_off[k] = cfg_offset; m_sh_len[k] = cfg_len;
        end
        if (mclr) m_cnt[k] = 0;
        else if (e_done[k]) m_cnt[k] = (m_cnt[k] + 1) % 65536;
        e_active[k] = m_act[k];
      end
      m_err = (m_err && !err_clr) || mbad;
      e_err = m_err;
      midx = int'(chn[2:0]);
      e_valid = 0; e_cc = 0; e_first = 0; e_last = 0;
      if (midx < NUM_CC) begin
        if (m_act[midx]) begin
          e_valid = 1;
          e_cc = 2'(midx);
          e_first = (m_seen[midx] == 1);
          e_last = (m_seen[midx] == m_len[midx]);
        end
      end
    end
  end

  logic [11:0] got_v, exp_v;
  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      got_v = {slot_valid, slot_cc, slot_first, slot_last, cc_active, occ_done, sync_err};
      exp_v = {e_valid, e_cc, e_first, e_last, e_active, e_done, e_err};
      n_vec++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cycle t=%0t got=%b required=%b (valid,cc,first,last,active,done,err)",
                 $time, got_v, exp_v);
      end
`ifdef PRACH_CC_SCHED_STATS_EN
      n_vec++;
      if (occ_cnt !== {16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])}) begin
        n_bad++;
        $display("FAIL model_occ_cnt t=%0t got=%h required=%h", $time, occ_cnt,
                 {16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])});
      end
`endif
    end
  end

  task automatic lit(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, req);
    end
  endtask

  task automatic drive(input bit s, input bit wr = 0, input logic [1:0] cc = 0, input bit en = 0,
                       input int off = 0, input int len = 0, input bit clr = 0, input bit r = 0);
    @(negedge clk);
    rst        = r;
    chn        = {5'(upper), 3'(phase)};
    sync_in    = s;
    cfg_wr     = wr;
    cfg_cc     = cc;
    cfg_en     = en;
    cfg_offset = 20'(off);
    cfg_len    = 20'(len);
    err_clr    = clr;
    phase      = (phase + 1) % 8;
    upper      = (upper + 3) % 32;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0);
  endtask

  task automatic to_phase(input int p);
    while (phase != p) drive(0);
  endtask

  int cnt2;
  bit seen_any;

  initial begin
    rst = 1; chn = 0; sync_in = 0; cfg_wr = 0; cfg_cc = 0; cfg_en = 0;
    cfg_offset = 0; cfg_len = 0; err_clr = 0;
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0);
    lit("rst_valid", slot_valid, 0);
    lit("rst_active", cc_active, 0);
    lit("rst_done", occ_done, 0);
    lit("rst_err", sync_err, 0);

    // CC0 offset 4 len 3: samples 4..6 on slot 0
    drive(0, 1, 0, 1, 4, 3);
    to_phase(0);
    drive(1);
    for (int i = 1; i <= 64; i++) begin
      drive(0);
      lit("t1_valid", slot_valid, (i == 33 || i == 41 || i == 49) ? 1 : 0);
      if (i == 33) lit("t1_first", slot_first, 1);
      if (i == 49) lit("t1_last", slot_last, 1);
      if (i == 41) lit("t1_mid_first", slot_first, 0);
      lit("t1_done", occ_done, (i == 57) ? 1 : 0);
    end

    // all CCs offset 0 len 2
    drive(0, 1, 0, 1, 0, 2);
    drive(0, 1, 1, 1, 0, 2);
    drive(0, 1, 2, 1, 0, 2);
    to_phase(0);
    drive(1);
    for (int i = 1; i <= 20; i++) begin
      drive(0);
      lit("t2_valid", slot_valid, ((i >= 1 && i <= 3) || (i >= 9 && i <= 11)) ? 1 : 0);
      if (i >= 1 && i <= 3) begin
        lit("t2_cc", slot_cc, i - 1);
        lit("t2_first", slot_first, 1);
        lit("t2_nlast", slot_last, 0);
      end
      if (i >= 9 && i <= 11) begin
        lit("t2_cc", slot_cc, i - 9);
        lit("t2_last", slot_last, 1);
      end
      lit("t2_done", occ_done, (i == 17) ? 7 : 0);
    end

    // cfg write coinciding with sync only lands in shadow
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 2, 0, 0, 0);
    to_phase(0);
    drive(1);
    to_phase(0);
    drive(1, 1, 1, 1, 1, 5);
    seen_any = 0;
    for (int i = 1; i <= 40; i++) begin
      drive(0);
      if (cc_active[1]) seen_any = 1;
    end
    lit("t3_cc1_idle_frame", seen_any, 0);
    to_phase(0);
    drive(1);
    for (int i = 1; i <= 9; i++) begin
      drive(0);
      if (i == 8) lit("t3_cc1_armed", cc_active, 0);
    end
    lit("t3_cc1_active", cc_active, 2);
    idle(48);

    // misaligned sync: flagged, time base keeps running
    drive(0, 1, 0, 1, 6, 2);
    to_phase(0);
    drive(1);
    for (int i = 1; i <= 60; i++) begin
      drive((i == 27 || i == 43) ? 1'b1 : 1'b0, 0, 0, 0, 0, 0,
            (i == 43 || i == 50 || i == 55) ? 1'b1 : 1'b0);
      if (i == 27) lit("t4_err_pre", sync_err, 0);
      if (i == 28) lit("t4_err_set", sync_err, 1);
      if (i == 44) lit("t4_err_clr_vs_new", sync_err, 1);
      if (i == 48) lit("t4_cc0_armed", cc_active[0], 0);
      if (i == 49) lit("t4_cc0_active", cc_active[0], 1);
      if (i == 51) lit("t4_err_cleared", sync_err, 0);
    end

    // CC2 len 10 survives a mid-occasion sync; shadow update deferred
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 2, 1, 0, 10);
    to_phase(0);
    drive(1);
    cnt2 = 0;
    for (int i = 1; i <= 120; i++) begin
      if (i == 20) drive(0, 1, 2, 1, 0, 2);
      else drive((i == 32) ? 1'b1 : 1'b0);
      if (slot_valid && slot_cc == 2) cnt2++;
      if (i == 50) lit("t5_cc2_still_active", cc_active[2], 1);
      if (i == 81) lit("t5_done", occ_done, 4);
    end
    lit("t5_samples", cnt2, 10);
    to_phase(0);
    drive(1);
    cnt2 = 0;
    for (int i = 1; i <= 24; i++) begin
      drive(0);
      if (slot_valid && slot_cc == 2) cnt2++;
    end
    lit("t5_new_len", cnt2, 2);

    // reset in the middle of an occasion
    drive(0, 1, 3, 1, 0, 1);
    drive(0, 1, 2, 1, 0, 8);
    to_phase(0);
    drive(1);
    idle(20);
    lit("t6_pre_active", cc_active, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    seen_any = 0;
    for (int i = 1; i <= 80; i++) begin
      drive(0);
      if (i == 1) begin
        lit("t6_valid", slot_valid, 0);
        lit("t6_active", cc_active, 0);
      end
      if (occ_done != 0 || slot_valid) seen_any = 1;
    end
    lit("t6_silent", seen_any, 0);
`ifdef PRACH_CC_SCHED_STATS_EN
    lit("t6_occ_cnt", (occ_cnt == 48'd0) ? 1 : 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
